// File: rtl/wb_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module   : wb_sched_pkg
// Purpose  : Shared widths, register count and arbitration result encoding
//            for the writeback scheduler.
// Revision : 1.0 - initial release
// ============================================================================
package wb_sched_pkg;

   localparam int ADDRESS_WIDTH_DEF = 5;
   localparam int DATA_WIDTH_DEF    = 32;
   localparam int NUM_REGS          = 2 ** ADDRESS_WIDTH_DEF;

   // Which execution path owns the write port this cycle
   typedef enum logic [1:0] {
      WB_NONE = 2'd0,
      WB_ALU  = 2'd1,
      WB_LSU  = 2'd2
   } wb_src_t;

endpackage : wb_sched_pkg
`default_nettype wire

// File: rtl/wb_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : wb_scoreboard
// Purpose  : Pending-destination scoreboard. One bit per architectural
//            register; raises the issue stall on RAW/WAW hazards.
// Revision : 1.0 - initial release
// ============================================================================
module wb_scoreboard
   import wb_sched_pkg::*;
#(
   parameter int ADDRESS_WIDTH = ADDRESS_WIDTH_DEF
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     iss_valid,
   input  logic [ADDRESS_WIDTH-1:0] iss_rs1,
   input  logic [ADDRESS_WIDTH-1:0] iss_rs2,
   input  logic [ADDRESS_WIDTH-1:0] iss_rd,
   input  logic                     iss_use_rs1,
   input  logic                     iss_use_rs2,
   input  logic                     clr_en,
   input  logic [ADDRESS_WIDTH-1:0] clr_idx,
   output logic                     iss_stall
);

   localparam int NREGS = 2 ** ADDRESS_WIDTH;

   logic [NREGS-1:0] pending_q;
   logic [NREGS-1:0] pending_d;
   logic             hazard;
   logic             accept;

   // Hazard compare: sources only when read, destination always (WAW)
   always_comb begin
      hazard    = (iss_use_rs1 & pending_q[iss_rs1])
                | (iss_use_rs2 & pending_q[iss_rs2])
                |  pending_q[iss_rd];
      iss_stall = rst | (iss_valid & hazard);
      accept    = iss_valid & ~iss_stall;
   end

   // Clear on committed write, set on accepted issue; x0 never pending.
   // Same-index set/clear cannot collide because the WAW check blocks it.
   always_comb begin
      pending_d = pending_q;
      if (clr_en) begin
         pending_d[clr_idx] = 1'b0;
      end
      if (accept && (iss_rd != '0)) begin
         pending_d[iss_rd] = 1'b1;
      end
      pending_d[0] = 1'b0;
   end

   // Pending vector register
   always_ff @(posedge clk) begin
      if (rst) begin
         pending_q <= '0;
      end else begin
         pending_q <= pending_d;
      end
   end

endmodule : wb_scoreboard
`default_nettype wire

// File: rtl/wb_sched.sv
`default_nettype none
// ============================================================================
// Module   : wb_sched
// Purpose  : Writeback scheduler. Arbitrates ALU vs load/store results onto
//            the single register-file write port with an ALU starvation
//            guard, and hosts the register scoreboard for issue stalls.
// Revision : 1.0 - initial release
// ============================================================================
module wb_sched
   import wb_sched_pkg::*;
#(
   parameter int ADDRESS_WIDTH = ADDRESS_WIDTH_DEF,
   parameter int DATA_WIDTH    = DATA_WIDTH_DEF,
   parameter int STARVE_LIMIT  = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   // issue stage
   input  logic                     iss_valid,
   input  logic [ADDRESS_WIDTH-1:0] iss_rs1,
   input  logic [ADDRESS_WIDTH-1:0] iss_rs2,
   input  logic [ADDRESS_WIDTH-1:0] iss_rd,
   input  logic                     iss_use_rs1,
   input  logic                     iss_use_rs2,
   output logic                     iss_stall,
   // ALU writeback path
   input  logic                     alu_valid,
   input  logic [ADDRESS_WIDTH-1:0] alu_rd,
   input  logic [DATA_WIDTH-1:0]    alu_data,
   output logic                     alu_ready,
   // load/store writeback path
   input  logic                     lsu_valid,
   input  logic [ADDRESS_WIDTH-1:0] lsu_rd,
   input  logic [DATA_WIDTH-1:0]    lsu_data,
   output logic                     lsu_ready,
   // register file write port
   output logic                     WE3,
   output logic [ADDRESS_WIDTH-1:0] AD3,
   output logic [DATA_WIDTH-1:0]    WD3
);

   // Counter is 4 bits wide, enough for the 1..15 limit range
   localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

   wb_src_t                  src;
   logic [3:0]               starve_cnt_q;
   logic [3:0]               starve_cnt_d;
   logic                     we3_q;
   logic                     we3_d;
   logic [ADDRESS_WIDTH-1:0] ad3_q;
   logic [ADDRESS_WIDTH-1:0] ad3_d;
   logic [DATA_WIDTH-1:0]    wd3_q;
   logic [DATA_WIDTH-1:0]    wd3_d;

   // Arbitration: LSU preferred, ALU forced once it has lost LIMIT times
   always_comb begin
      src = WB_NONE;
      if (!rst) begin
         if (alu_valid && lsu_valid) begin
            src = (starve_cnt_q == LIMIT) ? WB_ALU : WB_LSU;
         end else if (alu_valid) begin
            src = WB_ALU;
         end else if (lsu_valid) begin
            src = WB_LSU;
         end
      end
      alu_ready = (src == WB_ALU);
      lsu_ready = (src == WB_LSU);
   end

   // Starvation counter: count ALU losses (saturating), reset on ALU win
   always_comb begin
      starve_cnt_d = starve_cnt_q;
      if (src == WB_ALU) begin
         starve_cnt_d = '0;
      end else if (alu_valid && (starve_cnt_q != LIMIT)) begin
         starve_cnt_d = starve_cnt_q + 4'd1;
      end
   end

   // Write-port next state: winner's rd/data, enable suppressed for x0
   always_comb begin
      we3_d = 1'b0;
      ad3_d = ad3_q;
      wd3_d = wd3_q;
      case (src)
         WB_ALU: begin
            we3_d = (alu_rd != '0);
            ad3_d = alu_rd;
            wd3_d = alu_data;
         end
         WB_LSU: begin
            we3_d = (lsu_rd != '0);
            ad3_d = lsu_rd;
            wd3_d = lsu_data;
         end
         default: begin
            we3_d = 1'b0;
         end
      endcase
   end

   // Registered write port and starvation counter
   always_ff @(posedge clk) begin
      if (rst) begin
         starve_cnt_q <= '0;
         we3_q        <= 1'b0;
         ad3_q        <= '0;
         wd3_q        <= '0;
      end else begin
         starve_cnt_q <= starve_cnt_d;
         we3_q        <= we3_d;
         ad3_q        <= ad3_d;
         wd3_q        <= wd3_d;
      end
   end

   assign WE3 = we3_q;
   assign AD3 = ad3_q;
   assign WD3 = wd3_q;

   // Pending bits clear at the same edge the register file commits
   wb_scoreboard #(
      .ADDRESS_WIDTH (ADDRESS_WIDTH)
   ) u_sb (
      .clk         (clk),
      .rst         (rst),
      .iss_valid   (iss_valid),
      .iss_rs1     (iss_rs1),
      .iss_rs2     (iss_rs2),
      .iss_rd      (iss_rd),
      .iss_use_rs1 (iss_use_rs1),
      .iss_use_rs2 (iss_use_rs2),
      .clr_en      (we3_q),
      .clr_idx     (ad3_q),
      .iss_stall   (iss_stall)
   );

endmodule : wb_sched
`default_nettype wire

// File: tb/tb_wb_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_sched
// Purpose  : Self-checking bench for wb_sched. A cycle-level reference model
//            predicts readies/stall and queues the expected write-port value,
//            which is popped and compared after the following clock edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_sched;

   localparam int AW    = 5;
   localparam int DW    = 32;
   localparam int LIMIT = 4;

   typedef struct packed {
      logic          we;
      logic [AW-1:0] ad;
      logic [DW-1:0] wd;
   } wr_t;

   logic          clk = 1'b0;
   logic          rst;
   logic          iss_valid;
   logic [AW-1:0] iss_rs1, iss_rs2, iss_rd;
   logic          iss_use_rs1, iss_use_rs2;
   logic          iss_stall;
   logic          alu_valid;
   logic [AW-1:0] alu_rd;
   logic [DW-1:0] alu_data;
   logic          alu_ready;
   logic          lsu_valid;
   logic [AW-1:0] lsu_rd;
   logic [DW-1:0] lsu_data;
   logic          lsu_ready;
   logic          WE3;
   logic [AW-1:0] AD3;
   logic [DW-1:0] WD3;

   int n_tests = 0;
   int n_fail  = 0;

   // reference model state
   wr_t         exp_q[$];
   logic [31:0] m_pend   = '0;
   int          m_starve = 0;
   logic        m_we     = 1'b0;
   logic [AW-1:0] m_ad   = '0;
   logic [DW-1:0] m_wd   = '0;

   // values observed at the last mid-cycle sample
   logic obs_stall, obs_alu_ready, obs_lsu_ready;

   always #5 clk = ~clk;

   wb_sched #(
      .ADDRESS_WIDTH (AW),
      .DATA_WIDTH    (DW),
      .STARVE_LIMIT  (LIMIT)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .iss_valid   (iss_valid),
      .iss_rs1     (iss_rs1),
      .iss_rs2     (iss_rs2),
      .iss_rd      (iss_rd),
      .iss_use_rs1 (iss_use_rs1),
      .iss_use_rs2 (iss_use_rs2),
      .iss_stall   (iss_stall),
      .alu_valid   (alu_valid),
      .alu_rd      (alu_rd),
      .alu_data    (alu_data),
      .alu_ready   (alu_ready),
      .lsu_valid   (lsu_valid),
      .lsu_rd      (lsu_rd),
      .lsu_data    (lsu_data),
      .lsu_ready   (lsu_ready),
      .WE3         (WE3),
      .AD3         (AD3),
      .WD3         (WD3)
   );

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
      n_tests++;
      if (obs !== exp_v) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp_v);
      end
   endtask

   // One clock cycle: mid-cycle compare of combinational outputs against the
   // model, push expected write, then pop and compare after the edge.
   task automatic cycle();
      logic m_stall, m_acc;
      int   g;
      wr_t  e;
      @(negedge clk);
      m_stall = rst | (iss_valid & ((iss_use_rs1 & m_pend[iss_rs1]) |
                                    (iss_use_rs2 & m_pend[iss_rs2]) | m_pend[iss_rd]));
      m_acc   = iss_valid & ~m_stall;
      g = 0;
      if (!rst) begin
         if (alu_valid && lsu_valid) g = (m_starve == LIMIT) ? 1 : 2;
         else if (alu_valid)         g = 1;
         else if (lsu_valid)         g = 2;
      end
      obs_stall     = iss_stall;
      obs_alu_ready = alu_ready;
      obs_lsu_ready = lsu_ready;
      check_eq("iss_stall", iss_stall, m_stall);
      check_eq("alu_ready", alu_ready, g == 1);
      check_eq("lsu_ready", lsu_ready, g == 2);
      e.we = 1'b0; e.ad = m_ad; e.wd = m_wd;
      if (rst) begin
         e.ad = '0; e.wd = '0;
      end else if (g == 1) begin
         e.we = (alu_rd != 0); e.ad = alu_rd; e.wd = alu_data;
      end else if (g == 2) begin
         e.we = (lsu_rd != 0); e.ad = lsu_rd; e.wd = lsu_data;
      end
      exp_q.push_back(e);
      @(posedge clk);
      if (rst) begin
         m_pend   = '0;
         m_starve = 0;
      end else begin
         if (m_we) m_pend[m_ad] = 1'b0;
         if (m_acc && (iss_rd != 0)) m_pend[iss_rd] = 1'b1;
         m_pend[0] = 1'b0;
         if (g == 1) m_starve = 0;
         else if (alu_valid && (m_starve < LIMIT)) m_starve++;
      end
      #1;
      e = exp_q.pop_front();
      check_eq("WE3", WE3, e.we);
      check_eq("AD3", AD3, e.ad);
      check_eq("WD3", WD3, e.wd);
      check_eq("pending", dut.u_sb.pending_q, m_pend);
      m_we = e.we; m_ad = e.ad; m_wd = e.wd;
   endtask

   task automatic idle_inputs();
      iss_valid = 0; iss_rs1 = 0; iss_rs2 = 0; iss_rd = 0;
      iss_use_rs1 = 0; iss_use_rs2 = 0;
      alu_valid = 0; alu_rd = 0; alu_data = 0;
      lsu_valid = 0; lsu_rd = 0; lsu_data = 0;
   endtask

   initial begin
      idle_inputs();
      rst = 1;
      // reset with both requesters valid
      alu_valid = 1; alu_rd = 5'd1; alu_data = 32'h11;
      lsu_valid = 1; lsu_rd = 5'd2; lsu_data = 32'h22;
      iss_valid = 1; iss_rd = 5'd4;
      for (int i = 0; i < 2; i++) begin
         cycle();
         check_eq("rst_stall", obs_stall, 1);
         check_eq("rst_ready", {obs_alu_ready, obs_lsu_ready}, 2'b00);
         check_eq("rst_we3", {WE3, AD3, WD3}, 0);
      end
      rst = 0;
      idle_inputs();
      check_eq("rst_pending", dut.u_sb.pending_q, 0);
      check_eq("rst_starve", dut.starve_cnt_q, 0);

      // single-path ALU write
      alu_valid = 1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
      cycle();
      check_eq("alu_grant", obs_alu_ready, 1);
      check_eq("alu_we3", WE3, 1);
      check_eq("alu_ad3", AD3, 5);
      check_eq("alu_wd3", WD3, 32'hDEADBEEF);
      idle_inputs();
      cycle();
      check_eq("alu_we3_drop", WE3, 0);

      // RAW stall released by an LSU write to the same register
      iss_valid = 1; iss_rd = 5'd7;
      cycle();
      check_eq("raw_issue", obs_stall, 0);
      iss_rd = 5'd0; iss_rs1 = 5'd7; iss_use_rs1 = 1;
      cycle();
      check_eq("raw_stall", obs_stall, 1);
      lsu_valid = 1; lsu_rd = 5'd7; lsu_data = 32'h77;
      cycle();
      check_eq("raw_m_grant", obs_lsu_ready, 1);
      check_eq("raw_m_stall", obs_stall, 1);
      lsu_valid = 0;
      cycle();
      check_eq("raw_m1_stall", obs_stall, 1);
      cycle();
      check_eq("raw_m2_stall", obs_stall, 0);
      idle_inputs();

      // starvation: LSU x4, ALU on the 5th, repeating
      alu_valid = 1; alu_rd = 5'd10; alu_data = 32'hA1;
      lsu_valid = 1;
      for (int k = 0; k < 10; k++) begin
         lsu_rd = 5'(20 + k); lsu_data = 32'h100 + k;
         cycle();
         check_eq("starve_alu_grant", obs_alu_ready, (k % 5) == 4);
         if ((k % 5) == 4) check_eq("starve_cnt_zero", dut.starve_cnt_q, 0);
      end
      idle_inputs();

      // x0: issue rd=0 and write to x0
      iss_valid = 1; iss_rd = 5'd0;
      cycle();
      check_eq("x0_issue_stall", obs_stall, 0);
      idle_inputs();
      lsu_valid = 1; lsu_rd = 5'd0; lsu_data = 32'h1;
      cycle();
      check_eq("x0_lsu_ready", obs_lsu_ready, 1);
      check_eq("x0_we3", WE3, 0);
      idle_inputs();

      // reset in the middle of an ALU write to x3
      iss_valid = 1; iss_rd = 5'd3;
      cycle();
      idle_inputs();
      alu_valid = 1; alu_rd = 5'd3; alu_data = 32'h33;
      rst = 1;
      cycle();
      check_eq("mid_rst_ready", obs_alu_ready, 0);
      check_eq("mid_rst_we3", WE3, 0);
      check_eq("mid_rst_pend3", dut.u_sb.pending_q[3], 0);
      rst = 0;
      idle_inputs();
      iss_valid = 1; iss_rs1 = 5'd3; iss_use_rs1 = 1;
      cycle();
      check_eq("mid_rst_reader", obs_stall, 0);
      idle_inputs();

      // mixed random traffic against the model
      for (int r = 0; r < 60; r++) begin
         iss_valid   = 1'($urandom_range(0, 1));
         iss_rs1     = 5'($urandom_range(0, 7));
         iss_rs2     = 5'($urandom_range(0, 7));
         iss_rd      = 5'($urandom_range(0, 7));
         iss_use_rs1 = 1'($urandom_range(0, 1));
         iss_use_rs2 = 1'($urandom_range(0, 1));
         alu_valid   = 1'($urandom_range(0, 1));
         alu_rd      = 5'($urandom_range(0, 7));
         alu_data    = $urandom;
         lsu_valid   = 1'($urandom_range(0, 1));
         lsu_rd      = 5'($urandom_range(0, 7));
         lsu_data    = $urandom;
         cycle();
      end
      idle_inputs();
      cycle();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule : tb_wb_sched
`default_nettype wire
